// File: rtl/mem_storebuffer_pkg.sv
// ============================================================================
// Module   : mem_storebuffer_pkg
// Purpose  : Shared defaults and pointer-width helper for the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_storebuffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   // Index bits plus one wrap bit so full and empty are distinguishable.
   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_storebuffer_fwd_match.sv
// ============================================================================
// Module   : mem_storebuffer_fwd_match
// Purpose  : DEPTH-way address compare over occupied entries; youngest match wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_storebuffer_fwd_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
)(
   input  logic [$clog2(DEPTH)-1:0]    head_idx,
   input  logic [$clog2(DEPTH):0]      count,
   input  logic [DEPTH-1:0][AW-1:0]    ent_addr,
   input  logic [DEPTH-1:0][DW-1:0]    ent_data,
   input  logic [DEPTH-1:0][DW/8-1:0]  ent_strb,
   input  logic [AW-1:0]               fwd_addr,
   output logic                        fwd_hit,
   output logic [DW-1:0]               fwd_data,
   output logic [DW/8-1:0]             fwd_strb
);

   localparam int c_IDX_W = $clog2(DEPTH);

   logic [c_IDX_W-1:0] w_idx;

   // Walk from oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_strb = '0;
      w_idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = head_idx + c_IDX_W'(k);
         if ((k < int'(count)) && (ent_addr[w_idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[w_idx];
            fwd_strb = ent_strb[w_idx];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_storebuffer.sv
// ============================================================================
// Module   : mem_storebuffer
// Purpose  : In-order store buffer with speculative/committed split and dmem drain.
//            Define STOREBUFFER_FWD_EN to add store-to-load forwarding ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_storebuffer
   import mem_storebuffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   input  logic [AW-1:0]          s_addr,
   input  logic [DW-1:0]          s_data,
   input  logic [DW/8-1:0]        s_strb,
   output logic                   s_ready,
   input  logic                   commit_valid,
   input  logic                   bco_valid,
   input  logic                   snoop_hit,
   output logic                   dmem_valid,
   output logic [AW-1:0]          dmem_addr,
   output logic [DW-1:0]          dmem_data,
   output logic [DW/8-1:0]        dmem_strb,
   input  logic                   dmem_ready,
   output logic                   sb_empty,
   output logic [$clog2(DEPTH):0] sb_count
`ifdef STOREBUFFER_FWD_EN
   ,
   input  logic [AW-1:0]          fwd_addr,
   output logic                   fwd_hit,
   output logic [DW-1:0]          fwd_data,
   output logic [DW/8-1:0]        fwd_strb
`endif
);

   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_PTR_W = sb_ptr_w(DEPTH);

   logic [c_PTR_W-1:0]         r_head;
   logic [c_PTR_W-1:0]         r_cmt;
   logic [c_PTR_W-1:0]         r_tail;
   logic [DEPTH-1:0][AW-1:0]   r_addr;
   logic [DEPTH-1:0][DW-1:0]   r_data;
   logic [DEPTH-1:0][DW/8-1:0] r_strb;

   logic [c_PTR_W-1:0]         w_count;
   logic [c_PTR_W-1:0]         w_cmt_next;
   logic                       w_full;
   logic                       w_flush;
   logic                       w_enq;
   logic                       w_commit;
   logic                       w_drain;
   logic                       w_dmem_valid;

   assign w_count      = r_tail - r_head;
   assign w_full       = (w_count == c_PTR_W'(DEPTH));
   assign w_flush      = bco_valid | snoop_hit;
   assign w_enq        = s_valid & ~w_full & ~w_flush;
   assign w_commit     = commit_valid & (r_cmt != r_tail);
   assign w_dmem_valid = (r_head != r_cmt);
   assign w_drain      = w_dmem_valid & dmem_ready;
   assign w_cmt_next   = r_cmt + c_PTR_W'(w_commit);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head <= '0;
         r_cmt  <= '0;
         r_tail <= '0;
      end else begin
         r_head <= r_head + c_PTR_W'(w_drain);
         r_cmt  <= w_cmt_next;
         // A flush keeps anything committed this very cycle.
         if (w_flush)
            r_tail <= w_cmt_next;
         else
            r_tail <= r_tail + c_PTR_W'(w_enq);
      end
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr[r_tail[c_IDX_W-1:0]] <= s_addr;
         r_data[r_tail[c_IDX_W-1:0]] <= s_data;
         r_strb[r_tail[c_IDX_W-1:0]] <= s_strb;
      end
   end

   assign s_ready    = ~w_full;
   assign sb_count   = w_count;
   assign sb_empty   = (r_head == r_tail);
   assign dmem_valid = w_dmem_valid;
   assign dmem_addr  = r_addr[r_head[c_IDX_W-1:0]];
   assign dmem_data  = r_data[r_head[c_IDX_W-1:0]];
   assign dmem_strb  = r_strb[r_head[c_IDX_W-1:0]];

   a_commit_needs_spec: assert property (@(posedge clk) disable iff (reset)
      !(commit_valid && (r_cmt == r_tail)));

`ifdef STOREBUFFER_FWD_EN
   mem_storebuffer_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd_match (
      .head_idx (r_head[c_IDX_W-1:0]),
      .count    (w_count),
      .ent_addr (r_addr),
      .ent_data (r_data),
      .ent_strb (r_strb),
      .fwd_addr (fwd_addr),
      .fwd_hit  (fwd_hit),
      .fwd_data (fwd_data),
      .fwd_strb (fwd_strb)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_storebuffer.sv
// ============================================================================
// Module   : tb_mem_storebuffer
// Purpose  : Self-checking bench for mem_storebuffer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_storebuffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_data;
   logic [3:0]  s_strb;
   logic        s_ready;
   logic        commit_valid;
   logic        bco_valid;
   logic        snoop_hit;
   logic        dmem_valid;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_data;
   logic [3:0]  dmem_strb;
   logic        dmem_ready;
   logic        sb_empty;
   logic [2:0]  sb_count;
`ifdef STOREBUFFER_FWD_EN
   logic [31:0] fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [3:0]  fwd_strb;
`endif

   mem_storebuffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_valid      (s_valid),
      .s_addr       (s_addr),
      .s_data       (s_data),
      .s_strb       (s_strb),
      .s_ready      (s_ready),
      .commit_valid (commit_valid),
      .bco_valid    (bco_valid),
      .snoop_hit    (snoop_hit),
      .dmem_valid   (dmem_valid),
      .dmem_addr    (dmem_addr),
      .dmem_data    (dmem_data),
      .dmem_strb    (dmem_strb),
      .dmem_ready   (dmem_ready),
      .sb_empty     (sb_empty),
      .sb_count     (sb_count)
`ifdef STOREBUFFER_FWD_EN
      ,
      .fwd_addr     (fwd_addr),
      .fwd_hit      (fwd_hit),
      .fwd_data     (fwd_data),
      .fwd_strb     (fwd_strb)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   // Model: program-order queue; the first ncmt entries are committed.
   ent_t q[$];
   int   ncmt;
   int   checks   = 0;
   int   failures = 0;

   task automatic do_reset();
      reset = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_strb = '0;
      commit_valid = 1'b0; bco_valid = 1'b0; snoop_hit = 1'b0; dmem_ready = 1'b0;
`ifdef STOREBUFFER_FWD_EN
      fwd_addr = '0;
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete();
      ncmt = 0;
   endtask

   task automatic cyc(input bit sv, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input bit cv, input bit bco,
                      input bit snp, input bit dr);
      bit   fl, cm, dn, en;
      ent_t e;
      s_valid = sv; s_addr = a; s_data = d; s_strb = st;
      commit_valid = cv; bco_valid = bco; snoop_hit = snp; dmem_ready = dr;
      fl = bco | snp;
      cm = cv && (ncmt < q.size());
      dn = (ncmt > 0) && dr;
      en = sv && (q.size() < DEPTH) && !fl;
      e.a = a; e.d = d; e.s = st;
      if (cm) ncmt++;
      if (fl) while (q.size() > ncmt) void'(q.pop_back());
      if (en) q.push_back(e);
      if (dn) begin
         void'(q.pop_front());
         ncmt--;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
      checks++; if (dmem_valid !== 1'b0) begin failures++; $display("FAIL reset_dmem_valid got=%b exp=0", dmem_valid); end
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL reset_sb_empty got=%b exp=1", sb_empty); end
      checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL reset_sb_count got=%0d exp=0", sb_count); end
`ifdef STOREBUFFER_FWD_EN
      checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL reset_fwd_hit got=%b exp=0", fwd_hit); end
`endif
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 32'h10 * i, 32'hD0 + i, 4'hF, 0, 0, 0, 0);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
      checks++; if (sb_count !== 3'd4) begin failures++; $display("FAIL fill_sb_count got=%0d exp=4", sb_count); end
      checks++; if (dmem_valid !== 1'b0) begin failures++; $display("FAIL fill_dmem_valid got=%b exp=0", dmem_valid); end
      checks++; if (sb_empty !== 1'b0) begin failures++; $display("FAIL fill_sb_empty got=%b exp=0", sb_empty); end
   endtask

   task automatic test_commit_drain();
      do_reset();
      cyc(1, 32'h100, 32'hAA, 4'hF, 0, 0, 0, 1);
      checks++; if (dmem_valid !== 1'b0) begin failures++; $display("FAIL cd_spec_not_visible got=%b exp=0", dmem_valid); end
      cyc(0, 0, 0, 0, 1, 0, 0, 1);
      checks++; if (dmem_valid !== 1'b1) begin failures++; $display("FAIL cd_dmem_valid got=%b exp=1", dmem_valid); end
      checks++; if (dmem_addr !== 32'h100) begin failures++; $display("FAIL cd_dmem_addr got=%h exp=100", dmem_addr); end
      checks++; if (dmem_data !== 32'hAA) begin failures++; $display("FAIL cd_dmem_data got=%h exp=aa", dmem_data); end
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL cd_sb_empty got=%b exp=1", sb_empty); end
      checks++; if (dmem_valid !== 1'b0) begin failures++; $display("FAIL cd_dmem_idle got=%b exp=0", dmem_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 4 * i, 32'h30 + i, 4'h3, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (sb_count !== 3'd2) begin failures++; $display("FAIL flush_sb_count got=%0d exp=2", sb_count); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL flush_s_ready got=%b exp=1", s_ready); end
      checks++; if (dmem_addr !== 32'h300) begin failures++; $display("FAIL flush_drain0 got=%h exp=300", dmem_addr); end
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (dmem_addr !== 32'h304 || dmem_valid !== 1'b1) begin failures++; $display("FAIL flush_drain1 got=%h/%b exp=304/1", dmem_addr, dmem_valid); end
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", sb_empty); end
   endtask

   task automatic test_snoop();
      do_reset();
      cyc(1, 32'h400, 32'h44, 4'hF, 0, 0, 0, 0);
      cyc(1, 32'h500, 32'h55, 4'hF, 1, 0, 1, 0);
      checks++; if (sb_count !== 3'd1) begin failures++; $display("FAIL snoop_sb_count got=%0d exp=1", sb_count); end
      checks++; if (dmem_valid !== 1'b1 || dmem_addr !== 32'h400) begin failures++; $display("FAIL snoop_committed got=%b/%h exp=1/400", dmem_valid, dmem_addr); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      cyc(1, 32'h600, 32'h60, 4'hF, 0, 0, 0, 0);
      for (int i = 1; i < 4; i++) cyc(1, 32'h600 + 4 * i, 32'h60 + i, 4'hF, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (s_ready !== 1'b0 || sb_count !== 3'd4) begin failures++; $display("FAIL wrap_full got=%b/%0d exp=0/4", s_ready, sb_count); end
      cyc(1, 32'h700, 32'h70, 4'hF, 0, 0, 0, 1);
      checks++; if (sb_count !== 3'd3) begin failures++; $display("FAIL wrap_no_bypass got=%0d exp=3", sb_count); end
      checks++; if (dmem_addr !== 32'h604) begin failures++; $display("FAIL wrap_head got=%h exp=604", dmem_addr); end
      cyc(1, 32'h700, 32'h70, 4'hF, 0, 0, 0, 0);
      checks++; if (sb_count !== 3'd4) begin failures++; $display("FAIL wrap_enq_after got=%0d exp=4", sb_count); end
      for (int r = 0; r < 10; r++) begin
         cyc(1, 32'h800 + 4 * r, 32'h80 + r, 4'(r), (q.size() > ncmt), 0, 0, 1);
         checks++; if (sb_count !== 3'(q.size())) begin failures++; $display("FAIL wrap_count r=%0d got=%0d exp=%0d", r, sb_count, q.size()); end
         if (ncmt > 0) begin
            checks++; if (dmem_valid !== 1'b1 || dmem_addr !== q[0].a || dmem_data !== q[0].d) begin failures++; $display("FAIL wrap_order r=%0d got=%b/%h/%h exp=1/%h/%h", r, dmem_valid, dmem_addr, dmem_data, q[0].a, q[0].d); end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      cyc(1, 32'h900, 32'h90, 4'hF, 0, 0, 0, 0);
      cyc(1, 32'h904, 32'h91, 4'hF, 1, 0, 0, 0);
      checks++; if (dmem_valid !== 1'b1) begin failures++; $display("FAIL rmd_pre got=%b exp=1", dmem_valid); end
      dmem_ready = 1'b1;
      do_reset();
      checks++; if (dmem_valid !== 1'b0 || sb_count !== 3'd0) begin failures++; $display("FAIL rmd_post got=%b/%0d exp=0/0", dmem_valid, sb_count); end
   endtask

`ifdef STOREBUFFER_FWD_EN
   task automatic test_fwd();
      do_reset();
      cyc(1, 32'h200, 32'h11, 4'hF, 0, 0, 0, 0);
      cyc(1, 32'h200, 32'h22, 4'hF, 0, 0, 0, 0);
      fwd_addr = 32'h200; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=1/22", fwd_hit, fwd_data); end
      fwd_addr = 32'h204; #1;
      checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss got=%b exp=0", fwd_hit); end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 99) < 70, 32'($urandom_range(0, 7)) << 2, $urandom, 4'($urandom),
             (q.size() > ncmt) && ($urandom_range(0, 99) < 50),
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
             $urandom_range(0, 99) < 60);
         checks++; if (s_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_s_ready n=%0d got=%b exp=%b", n, s_ready, q.size() < DEPTH); end
         checks++; if (sb_count !== 3'(q.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, sb_count, q.size()); end
         checks++; if (sb_empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, sb_empty, q.size() == 0); end
         checks++; if (dmem_valid !== (ncmt > 0)) begin failures++; $display("FAIL rnd_dmem_valid n=%0d got=%b exp=%b", n, dmem_valid, ncmt > 0); end
         if (ncmt > 0) begin
            checks++; if (dmem_addr !== q[0].a || dmem_data !== q[0].d || dmem_strb !== q[0].s) begin failures++; $display("FAIL rnd_dmem n=%0d got=%h/%h/%h exp=%h/%h/%h", n, dmem_addr, dmem_data, dmem_strb, q[0].a, q[0].d, q[0].s); end
         end
`ifdef STOREBUFFER_FWD_EN
         begin
            bit          eh = 1'b0;
            logic [31:0] ed = '0;
            logic [3:0]  es = '0;
            fwd_addr = 32'($urandom_range(0, 7)) << 2;
            #1;
            for (int i = q.size() - 1; i >= 0 && !eh; i--) begin
               if (q[i].a == fwd_addr) begin eh = 1'b1; ed = q[i].d; es = q[i].s; end
            end
            checks++; if (fwd_hit !== eh || (eh && (fwd_data !== ed || fwd_strb !== es))) begin failures++; $display("FAIL rnd_fwd n=%0d got=%b/%h/%h exp=%b/%h/%h", n, fwd_hit, fwd_data, fwd_strb, eh, ed, es); end
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_commit_drain();
      test_flush();
      test_snoop();
      test_full_wrap();
      test_reset_mid_drain();
`ifdef STOREBUFFER_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
